// File: rtl/alu_iter.sv
// Handshaked ALU: single-cycle logic/arith/compare/shift ops, plus iterative
// shift-add multiply and restoring unsigned divide/remainder.
module alu_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLT  = 4'd5,
    OP_SLTU = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9,
    OP_MUL  = 4'd10,
    OP_DIVU = 4'd11,
    OP_REMU = 4'd12
  } op_t;

  state_t           state, state_nx;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] acc;       // product accumulator / partial remainder
  logic [WIDTH-1:0] opa;       // multiplicand (shifts left) / dividend->quotient
  logic [WIDTH-1:0] opb;       // multiplier (shifts right) / divisor
  logic             rem_q;
  logic [WIDTH-1:0] result_q;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] simple_res;
  logic             is_mul;
  logic             is_div;
  logic [WIDTH-1:0] mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             qbit;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;

  assign shamt  = b[SHW-1:0];
  assign is_mul = (op == OP_MUL);
  assign is_div = ((op == OP_DIVU) || (op == OP_REMU)) && (b != '0);

  always_comb begin
    simple_res = '0;
    case (op)
      OP_AND:  simple_res = a & b;
      OP_OR:   simple_res = a | b;
      OP_ADD:  simple_res = a + b;
      OP_SUB:  simple_res = a - b;
      OP_XOR:  simple_res = a ^ b;
      OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: simple_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  simple_res = a << shamt;
      OP_SRL:  simple_res = a >> shamt;
      OP_SRA:  simple_res = $unsigned($signed(a) >>> shamt);
      // divide ops only take this path when the divisor is zero
      OP_DIVU: simple_res = '1;
      OP_REMU: simple_res = a;
      default: simple_res = '0;
    endcase
  end

  assign mul_sum = acc + (opb[0] ? opa : '0);

  assign rem_sh = {acc, opa[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, opb};
  assign qbit   = ~trial[WIDTH];
  assign rem_nx = qbit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_nx = {opa[WIDTH-2:0], qbit};

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (is_mul)      state_nx = MUL;
          else if (is_div) state_nx = DIV;
          else             state_nx = DONE;
        end
      end
      MUL:     if (cnt == '0) state_nx = DONE;
      DIV:     if (cnt == '0) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      opa      <= '0;
      opb      <= '0;
      rem_q    <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opa   <= a;
            opb   <= b;
            acc   <= '0;
            cnt   <= SHW'(WIDTH-1);
            rem_q <= (op == OP_REMU);
            if (!(is_mul || is_div)) result_q <= simple_res;
          end
        end
        MUL: begin
          acc <= mul_sum;
          opa <= opa << 1;
          opb <= opb >> 1;
          if (cnt != '0) cnt <= cnt - 1'b1;
          else           result_q <= mul_sum;
        end
        DIV: begin
          acc <= rem_nx;
          opa <= quo_nx;
          if (cnt != '0) cnt <= cnt - 1'b1;
          else           result_q <= rem_q ? rem_nx : quo_nx;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = result_q;
  assign zero      = (result_q == '0);

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: expectations queued at accept, checked on retire.
module tb_alu_iter;

  localparam int unsigned W = 32;

  typedef enum logic [3:0] {
    T_AND = 4'd0, T_OR = 4'd1, T_ADD = 4'd2, T_SUB = 4'd3, T_XOR = 4'd4,
    T_SLT = 4'd5, T_SLTU = 4'd6, T_SLL = 4'd7, T_SRL = 4'd8, T_SRA = 4'd9,
    T_MUL = 4'd10, T_DIVU = 4'd11, T_REMU = 4'd12
  } top_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         zero;
  logic         busy;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;

  logic [W-1:0] exp_q[$];
  int unsigned  lat_q[$];
  int unsigned  acc_q[$];

  alu_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] p;
    case (o)
      4'd0:  return x & y;
      4'd1:  return x | y;
      4'd2:  return x + y;
      4'd3:  return x - y;
      4'd4:  return x ^ y;
      4'd5:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd6:  return (x < y) ? 32'd1 : 32'd0;
      4'd7:  return x << y[4:0];
      4'd8:  return x >> y[4:0];
      4'd9:  return $unsigned($signed(x) >>> y[4:0]);
      4'd10: begin p = 64'(x) * 64'(y); return p[31:0]; end
      4'd11: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      4'd12: return (y == 0) ? x : x % y;
      default: return '0;
    endcase
  endfunction

  function automatic int unsigned lat_of(input logic [3:0] o, input logic [W-1:0] y);
    if (o == 4'd10) return W + 1;
    if ((o == 4'd11 || o == 4'd12) && y != 0) return W + 1;
    return 1;
  endfunction

  // Retire monitor: samples mid-cycle, pops one expectation per retired result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check("sb_depth", 64'(exp_q.size()), 64'd1);
      if (exp_q.size() != 0) begin
        logic [W-1:0] e;
        int unsigned  l, ac;
        e  = exp_q.pop_front();
        l  = lat_q.pop_front();
        ac = acc_q.pop_front();
        check("result", 64'(result), 64'(e));
        check("zero", 64'(zero), 64'(e == 0));
        if (l != 0) check("latency", 64'(cyc - ac + 1), 64'(l));
      end
    end
  end

  // Called and returns in the phase just after a rising edge.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] e, input int unsigned lat, input bit push);
    int unsigned n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 64'(in_ready), 64'd1);
      return;
    end
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 4'($urandom); a = $urandom; b = $urandom;
    if (push) begin
      exp_q.push_back(e);
      lat_q.push_back(lat);
      acc_q.push_back(cyc);
    end
  endtask

  task automatic wait_done();
    int unsigned n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    check("drain", 64'({exp_q.size() == 0, in_ready}), 64'b11);
  endtask

  initial begin
    logic [3:0]   o;
    logic [W-1:0] x, y;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result", 64'(result), 64'd0);

    issue(T_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 1'b1);
    @(posedge clk); #1;
    check("add_in_ready_again", 64'(in_ready), 64'd1);
    check("add_busy_clear", 64'(busy), 64'd0);

    issue(T_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1, 1'b1);            wait_done();
    issue(T_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, 1'b1);            wait_done();
    issue(T_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 1'b1);           wait_done();
    issue(T_SRA, 32'h8000_0000, 32'h24, 32'hF800_0000, 1, 1'b1);   wait_done();
    issue(4'd14, 32'h1234, 32'h5678, 32'd0, 1, 1'b1);              wait_done();

    // MUL with stray in_valid pulses that must not be accepted
    issue(T_MUL, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, W + 1, 1'b1);
    for (int i = 0; i < 32; i++) begin
      check("mul_in_ready", 64'(in_ready), 64'd0);
      check("mul_busy", 64'(busy), 64'd1);
      in_valid = (i < 20) && i[0];
      op = T_ADD;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_done();

    issue(T_DIVU, 32'd100, 32'd7, 32'd14, W + 1, 1'b1);            wait_done();
    issue(T_REMU, 32'd100, 32'd7, 32'd2, W + 1, 1'b1);             wait_done();
    issue(T_DIVU, 32'hDEAD_BEEF, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);   wait_done();
    issue(T_REMU, 32'd9, 32'd0, 32'd9, 1, 1'b1);                   wait_done();

    // Back-pressure: result held while out_ready is low
    out_ready = 1'b0;
    issue(T_ADD, 32'd3, 32'd4, 32'd7, 0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_result", 64'(result), 64'd7);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    op = T_ADD; a = 32'd10; b = 32'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    check("bp_retired", 64'(out_valid), 64'd0);
    check("bp_no_accept_on_retire", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(32'd30); lat_q.push_back(1); acc_q.push_back(cyc);
    wait_done();

    // Reset during the 10th divide iteration discards the op
    issue(T_DIVU, 32'd1000, 32'd3, '0, 0, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_result", 64'(result), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    issue(T_ADD, 32'd1, 32'd1, 32'd2, 1, 1'b1);                    wait_done();

    for (int i = 0; i < 24; i++) begin
      o = 4'($urandom_range(0, 15));
      x = $urandom;
      y = $urandom;
      if (i % 4 == 0) y = y & 32'h1F;
      if ((o == 4'd11 || o == 4'd12) && (i % 6 == 0)) y = '0;
      issue(o, x, y, model(o, x, y), lat_of(o, y), 1'b1);
      wait_done();
    end

    repeat (3) begin @(posedge clk); #1; end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
